// File: rtl/dcm_prog_seq.sv
// Upstream program sequencer for the dcm: debounced buttons, selection, and an issue/wait/retry handshake.
// Optional feature: define DCM_PROG_AUTO_LOAD_EN so that an up/down change of cur_sel also starts a transfer.
module dcm_prog_seq #(
    parameter int unsigned PROG_W      = 3,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_load,
    input  logic [PROG_W-1:0] prog_out,
    output logic [PROG_W-1:0] prog_in,
    output logic              update,
    output logic [PROG_W-1:0] cur_sel,
    output logic              busy,
    output logic              err
);

    localparam int unsigned NumBtn = 3;
    localparam int unsigned DebW   = $clog2(DEB_CYCLES) + 1;
    localparam int unsigned TmoW   = $clog2(ACK_TIMEOUT) + 1;
    localparam int unsigned RtyW   = $clog2(MAX_RETRY) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StFail
    } state_e;

    // Button lanes: bit 0 up, bit 1 down, bit 2 load.
    logic [NumBtn-1:0]            btn_raw;
    logic [NumBtn-1:0]            sync1_q, sync2_q;
    logic [NumBtn-1:0]            lvl_q, lvl_d;
    logic [NumBtn-1:0]            evt_q, evt_d;
    logic [NumBtn-1:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;

    logic [PROG_W-1:0] cur_sel_q, cur_sel_d;
    logic [PROG_W-1:0] req_q, req_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RtyW-1:0]   retry_cnt_q, retry_cnt_d;
    logic              err_q, err_d;
    state_e            state_q, state_d;

    logic up_evt, down_evt, load_evt, start;

    assign btn_raw = {btn_load, btn_down, btn_up};

    always_comb begin
        lvl_d     = lvl_q;
        evt_d     = '0;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < NumBtn; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
                    lvl_d[i]     = ~lvl_q[i];
                    deb_cnt_d[i] = '0;
                    evt_d[i]     = ~lvl_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    assign up_evt   = evt_q[0];
    assign down_evt = evt_q[1];
    assign load_evt = evt_q[2];

    always_comb begin
        cur_sel_d = cur_sel_q;
        if (up_evt && !down_evt) begin
            cur_sel_d = cur_sel_q + PROG_W'(1);
        end else if (down_evt && !up_evt) begin
            cur_sel_d = cur_sel_q - PROG_W'(1);
        end
    end

`ifdef DCM_PROG_AUTO_LOAD_EN
    logic auto_req_q, auto_req_d;

    // One-cycle request: dropped if the FSM is not idle when it arrives.
    assign auto_req_d = up_evt ^ down_evt;
    assign start      = load_evt | auto_req_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_req_q <= 1'b0;
        end else begin
            auto_req_q <= auto_req_d;
        end
    end
`else
    assign start = load_evt;
`endif

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        err_d       = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    req_d       = cur_sel_q;
                    retry_cnt_d = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                tmo_cnt_d = '0;
                state_d   = StWait;
            end
            StWait: begin
                tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                // A match wins over a timeout landing in the same cycle.
                if (prog_out == req_q) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end else if (tmo_cnt_q == TmoW'(ACK_TIMEOUT - 1)) begin
                    if (retry_cnt_q < RtyW'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + RtyW'(1);
                        state_d     = StIssue;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StFail;
                    end
                end
            end
            StFail: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            lvl_q       <= '0;
            evt_q       <= '0;
            deb_cnt_q   <= '0;
            cur_sel_q   <= '0;
            req_q       <= '0;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
            err_q       <= 1'b0;
            state_q     <= StIdle;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            lvl_q       <= lvl_d;
            evt_q       <= evt_d;
            deb_cnt_q   <= deb_cnt_d;
            cur_sel_q   <= cur_sel_d;
            req_q       <= req_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            err_q       <= err_d;
            state_q     <= state_d;
        end
    end

    // Decoded straight from the state flop so reset kills the strobe without waiting for a clock.
    assign update  = (state_q == StIssue);
    assign busy    = (state_q == StIssue) || (state_q == StWait);
    assign prog_in = req_q;
    assign cur_sel = cur_sel_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dcm_prog_seq.sv
// Bench for dcm_prog_seq: cycle model of the button/selection/transfer rules, a stub dcm, directed scenarios.
module tb_dcm_prog_seq;

    localparam int unsigned TMO   = 16;
    localparam int unsigned RETRY = 2;
    localparam int unsigned DEB   = 4;

    localparam logic [1:0] PhIdle  = 2'd0;
    localparam logic [1:0] PhIssue = 2'd1;
    localparam logic [1:0] PhWait  = 2'd2;
    localparam logic [1:0] PhFail  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0;
    logic [2:0] prog_out = 3'd0;
    logic [2:0] prog_in, cur_sel;
    logic       update, busy, err;

    dcm_prog_seq dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_load (btn_load),
        .prog_out (prog_out),
        .prog_in  (prog_in),
        .update   (update),
        .cur_sel  (cur_sel),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state after each edge; p1/p2 are what the synchronizer has seen of each raw button.
    typedef struct packed {
        logic [2:0]      p1;
        logic [2:0]      p2;
        logic [2:0]      lvl;
        logic [2:0]      evt;
        logic [2:0][7:0] run;
        logic [1:0]      phase;
        logic [7:0]      waited;
        logic [7:0]      tries;
        logic            auto_req;
        logic [2:0]      sel;
        logic [2:0]      req;
        logic            err;
    } mstate_t;

    mstate_t ms = '0;

    function automatic mstate_t model_next(input mstate_t s, input logic [2:0] raw,
                                           input logic [2:0] po);
        mstate_t n;
        logic    up, dn, ld;
        n  = s;
        up = s.evt[0];
        dn = s.evt[1];
        ld = s.evt[2] || s.auto_req;
        n.auto_req = 1'b0;
        case (s.phase)
            PhIdle: if (ld) begin
                n.req   = s.sel;
                n.tries = 8'd0;
                n.phase = PhIssue;
            end
            PhIssue: begin
                n.waited = 8'd0;
                n.phase  = PhWait;
            end
            PhWait: begin
                n.waited = s.waited + 8'd1;
                if (po == s.req) begin
                    n.err   = 1'b0;
                    n.phase = PhIdle;
                end else if (n.waited == 8'(TMO)) begin
                    if (s.tries < 8'(RETRY)) begin
                        n.tries = s.tries + 8'd1;
                        n.phase = PhIssue;
                    end else begin
                        n.err   = 1'b1;
                        n.phase = PhFail;
                    end
                end
            end
            default: n.phase = PhIdle;
        endcase
        if (up != dn) begin
            n.sel = up ? s.sel + 3'd1 : s.sel - 3'd1;
`ifdef DCM_PROG_AUTO_LOAD_EN
            n.auto_req = 1'b1;
`endif
        end
        for (int b = 0; b < 3; b++) begin
            n.evt[b] = 1'b0;
            if (s.p2[b] != s.lvl[b]) begin
                n.run[b] = s.run[b] + 8'd1;
                if (n.run[b] == 8'(DEB)) begin
                    n.lvl[b] = ~s.lvl[b];
                    n.evt[b] = ~s.lvl[b];
                    n.run[b] = 8'd0;
                end
            end else begin
                n.run[b] = 8'd0;
            end
        end
        n.p2 = s.p1;
        n.p1 = raw;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) ms <= '0;
        else      ms <= model_next(ms, {btn_load, btn_down, btn_up}, prog_out);
    end

    // Stub dcm: reports the requested program dcm_delay cycles after update, or 0 when disabled.
    bit         dcm_en    = 1'b1;
    int         dcm_delay = 3;
    int         dcm_cnt   = 0;
    logic [2:0] dcm_val   = 3'd0;
    always @(negedge clk) begin
        if (!dcm_en) begin
            prog_out <= 3'd0;
            dcm_cnt  <= 0;
        end else begin
            if (dcm_cnt == 1) prog_out <= dcm_val;
            if (dcm_cnt > 0)  dcm_cnt  <= dcm_cnt - 1;
            if (update === 1'b1) begin
                dcm_cnt <= dcm_delay;
                dcm_val <= prog_in;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_total = 0;
    int pulse_cyc[$];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic compare_cycle();
        logic [8:0] act, exp;
        act = {prog_in, update, cur_sel, busy, err};
        exp = {ms.req, ms.phase == PhIssue, ms.sel,
               (ms.phase == PhIssue) || (ms.phase == PhWait), ms.err};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL cycle_compare @%0d {prog_in,update,cur_sel,busy,err}: got %b expected %b",
                      cyc, act, exp);
        if (update === 1'b1) begin
            pulse_total++;
            pulse_cyc.push_back(cyc);
        end
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        @(negedge clk);
        {btn_load, btn_down, btn_up} = m;
        repeat (hold) @(negedge clk);
        {btn_load, btn_down, btn_up} = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_done(input int base, input int max, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (pulse_total > base && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(nm, int'(ok), 1);
    endtask

    task automatic wait_update(input int max, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (update === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check(nm, int'(ok), 1);
    endtask

    task automatic flush_prog_out();
        dcm_en = 1'b0;
        repeat (2) @(negedge clk);
        dcm_en = 1'b1;
    endtask

    int base;

    initial begin
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Reset held while buttons chatter.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            {btn_load, btn_down, btn_up} = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        {btn_load, btn_down, btn_up} = 3'b000;
        check("reset_no_update", pulse_total, 0);
        check("reset_busy_err", int'({busy, err}), 0);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("post_reset_cur_sel", int'(cur_sel), 0);

        // Two up presses then load of 2.
        press(3'b001, 6);
        press(3'b001, 6);
        check("two_ups_sel", int'(cur_sel), 2);
        base = pulse_total;
        press(3'b100, 6);
        wait_done(base, 60, "load2_done");
        check("load2_pulses", pulse_total - base, 1);
        check("load2_prog_in", int'(prog_in), 2);
        check("load2_err", int'(err), 0);

        // Wrap both ways and the up+down collision.
        press(3'b010, 6);
        press(3'b010, 6);
        check("down_to_0", int'(cur_sel), 0);
        press(3'b010, 6);
        check("wrap_down_7", int'(cur_sel), 7);
        press(3'b001, 6);
        check("wrap_up_0", int'(cur_sel), 0);
        press(3'b011, 6);
        check("up_down_same", int'(cur_sel), 0);

        // Glitch shorter than the debounce window, then a real press.
        press(3'b001, DEB - 1);
        check("glitch_ignored", int'(cur_sel), 0);
        press(3'b001, DEB + 2);
        check("held_press", int'(cur_sel), 1);

        // Request 5 against a dcm stuck at 0: three issues, then err.
        repeat (4) press(3'b001, 6);
        check("sel_5", int'(cur_sel), 5);
        dcm_en = 1'b0;
        base = pulse_total;
        press(3'b100, 6);
        wait_done(base, 120, "fail_done");
        check("fail_pulses", pulse_total - base, 3);
        if (pulse_total - base >= 3) begin
            check("fail_gap1", pulse_cyc[base + 1] - pulse_cyc[base], 17);
            check("fail_gap2", pulse_cyc[base + 2] - pulse_cyc[base + 1], 17);
        end
        check("fail_err", int'(err), 1);
        check("fail_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("err_sticky", int'(err), 1);

        // A good load clears err.
        dcm_en = 1'b1;
        base = pulse_total;
        press(3'b100, 6);
        wait_done(base, 60, "recover_done");
        check("recover_err", int'(err), 0);
        check("recover_pulses", pulse_total - base, 1);
        check("recover_prog_in", int'(prog_in), 5);

        // Second load lands while waiting on a slow dcm.
        flush_prog_out();
        dcm_delay = 14;
        base = pulse_total;
        @(negedge clk);
        btn_load = 1'b1;
        wait_update(20, "slow_first_update");
        btn_load = 1'b0;
        repeat (6) @(negedge clk);
        btn_load = 1'b1;
        repeat (6) @(negedge clk);
        btn_load = 1'b0;
        wait_done(base, 60, "slow_done");
        check("load_in_wait_pulses", pulse_total - base, 1);
        dcm_delay = 3;
        repeat (12) @(negedge clk);

        // Reset in the middle of an update strobe.
        @(negedge clk);
        btn_load = 1'b1;
        wait_update(20, "midreset_update");
        #2 rst = 1'b0;
        #1;
        check("midreset_update_low", int'(update), 0);
        check("midreset_busy_low", int'(busy), 0);
        btn_load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("midreset_sel", int'(cur_sel), 0);

        // An up press alone: transfer only with auto-load.
        base = pulse_total;
        press(3'b001, 6);
`ifdef DCM_PROG_AUTO_LOAD_EN
        wait_done(base, 60, "auto_done");
        check("auto_pulses", pulse_total - base, 1);
        check("auto_prog_in", int'(prog_in), 1);
`else
        repeat (10) @(negedge clk);
        check("no_auto_pulses", pulse_total - base, 0);
        check("no_auto_busy", int'(busy), 0);
`endif
        check("final_sel", int'(cur_sel), 1);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
